wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- General-purpose register file at the consuming end of the MEM/WB pipeline register; the write-back stage writes into it.
- Accepts the registered write-back triple (address, data, enable) and commits it on the rising clock edge.
- Serves two combinational read ports to the decode stage, with same-cycle write-to-read bypass.
- Emits a registered debug/trace record of every committed write, plus a committed-write counter, for golden-trace comparison.

Parameters:
- DATA_W, 32, register and data width (`RegBus).
- ADDR_W, 5, register address width (`RegAddrBus).
- NUM_REGS, 32, number of architectural registers (`RegNum); register 0 is hard-wired zero.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high (`RstEnable = 1'b1).
- wb_write  input  1  write-back enable from the MEM/WB register (`WriteEnable = 1).
- wb_waddr  input  ADDR_W  write-back destination register.
- wb_wdata  input  DATA_W  write-back data.
- wb_pc  input  32  PC of the retiring instruction; used for trace only.
- re1  input  1  read enable, port 1 (`ReadEnable = 1).
- raddr1  input  ADDR_W  read address, port 1.
- rdata1  output  DATA_W  read data, port 1 (combinational).
- re2  input  1  read enable, port 2.
- raddr2  input  ADDR_W  read address, port 2.
- rdata2  output  DATA_W  read data, port 2 (combinational).
- debug_wb_pc  output  32  PC of the last committed write (registered).
- debug_wb_rf_wen  output  4  byte-write enables of the last committed write (registered).
- debug_wb_rf_wnum  output  ADDR_W  destination of the last committed write (registered).
- debug_wb_rf_wdata  output  DATA_W  data of the last committed write (registered).
- wr_count  output  32  number of committed writes since reset (registered).

Behaviour:
- Reset, synchronous:
  - When rst=1 at a rising edge, all NUM_REGS entries clear to `ZeroWord.
  - All debug_* outputs clear to 0 and wr_count clears to 0.
  - A write presented in the same cycle as reset is dropped.
- Reads while rst=1: rdata1 and rdata2 are forced to `ZeroWord, regardless of re/raddr.
- Commit condition: commit = wb_write=1 AND wb_waddr!=0 AND rst=0.
  - On commit, regs[wb_waddr] <= wb_wdata at the rising edge, so the write is visible to array reads from the next cycle.
  - A write to register 0 is silently discarded; register 0 always reads 0.
- Read port n (identical logic for both ports), priority order:
  1. rst=1 -> 0.
  2. re_n=0 -> 0.
  3. raddr_n=0 -> 0.
  4. commit AND raddr_n==wb_waddr -> wb_wdata (bypass; new data in the same cycle).
  5. Otherwise -> regs[raddr_n].
- Both ports may read the same address as each other and as the write; both then receive the bypassed data.
- Trace record, registered with 1-cycle latency after the edge on which wb_* is presented:
  - debug_wb_rf_wen <= {4{commit}}.
  - debug_wb_rf_wnum <= commit ? wb_waddr : 0.
  - debug_wb_rf_wdata <= commit ? wb_wdata : 0.
  - debug_wb_pc <= wb_pc on every non-reset cycle.
- wr_count: increments by 1 on each commit and wraps modulo 2^32 (0xFFFFFFFF -> 0). It does not increment for $0 writes or wb_write=0.
- No stall or flush input: the block writes every cycle that wb_write is asserted. Stall and flush are resolved upstream in the MEM/WB register.

Decomposition:
- Shared Defines.v holds RstEnable, WriteEnable, ReadEnable, ZeroWord, NOPRegAddr, RegAddrBus, RegBus, RegNum.
- Add to Defines.v: TraceWenBus [3:0], TraceWenAll 4'hF.
- Sub-module: wb_trace_reg, containing the registered debug_* record and wr_count, driven by commit/wb_waddr/wb_wdata/wb_pc.
- The storage array and read/bypass muxes stay in wb_regfile.

Test Plan:
- Reset then read: hold rst=1 for 2 cycles, then re1=re2=1, raddr1=5, raddr2=31 -> rdata1=rdata2=0; debug_wb_rf_wen=0; wr_count=0.
- Write then read: wb_write=1, waddr=3, wdata=0xDEADBEEF for one cycle; next cycle raddr1=3 -> rdata1=0xDEADBEEF, debug_wb_rf_wen=4'hF, wnum=3, wr_count=1.
- Bypass: same cycle, wb_write=1, waddr=7, wdata=0x12345678, re1=re2=1, raddr1=raddr2=7 -> both rdata=0x12345678 combinationally before the edge.
- $0 write: wb_write=1, waddr=0, wdata=0xFFFFFFFF -> raddr1=0 gives 0 in the same cycle and the next; debug_wb_rf_wen=0; wr_count unchanged.
- Reset collision: rst=1 with wb_write=1, waddr=9, wdata=0xA5A5A5A5 -> after reset, raddr1=9 gives 0 and wr_count=0. Also, re1=0 with raddr1=9 after a valid write gives 0.
- Counter wrap: force wr_count to 0xFFFFFFFE, then issue 3 commits -> 0xFFFFFFFF, 0x00000000, 0x00000001.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module : wb_regfile_pkg
// Shared constants, trace types and helpers for the write-back register file.
// Rev    : 1.0
// ============================================================================
package wb_regfile_pkg;

   localparam logic        c_rst_enable   = 1'b1;
   localparam logic        c_write_enable = 1'b1;
   localparam logic        c_read_enable  = 1'b1;
   localparam logic [31:0] c_zero_word    = 32'h0000_0000;
   localparam logic [4:0]  c_nop_reg_addr = 5'd0;
   localparam int          c_reg_w        = 32;
   localparam int          c_reg_addr_w   = 5;
   localparam int          c_reg_num      = 32;

   typedef logic [3:0] trace_wen_t;
   localparam trace_wen_t  c_trace_wen_all = 4'hF;

   // A committed write always touches the whole word.
   function automatic trace_wen_t f_trace_wen(input logic commit);
      return commit ? c_trace_wen_all : '0;
   endfunction

endpackage
`default_nettype wire

// File: rtl/wb_regfile_if.sv
`default_nettype none
// ============================================================================
// Module : wb_regfile_if
// Write-back, decode read and trace signals of the register file.
// Rev    : 1.0
// ============================================================================
interface wb_regfile_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              wb_write;
   logic [ADDR_W-1:0] wb_waddr;
   logic [DATA_W-1:0] wb_wdata;
   logic [31:0]       wb_pc;

   logic              re1;
   logic [ADDR_W-1:0] raddr1;
   logic [DATA_W-1:0] rdata1;
   logic              re2;
   logic [ADDR_W-1:0] raddr2;
   logic [DATA_W-1:0] rdata2;

   logic [31:0]       debug_wb_pc;
   logic [3:0]        debug_wb_rf_wen;
   logic [ADDR_W-1:0] debug_wb_rf_wnum;
   logic [DATA_W-1:0] debug_wb_rf_wdata;
   logic [31:0]       wr_count;

   modport master (
      output wb_write, wb_waddr, wb_wdata, wb_pc,
      output re1, raddr1, re2, raddr2,
      input  rdata1, rdata2,
      input  debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata, wr_count
   );

   modport slave (
      input  wb_write, wb_waddr, wb_wdata, wb_pc,
      input  re1, raddr1, re2, raddr2,
      output rdata1, rdata2,
      output debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata, wr_count
   );
endinterface
`default_nettype wire

// File: rtl/wb_trace_reg.sv
`default_nettype none
// ============================================================================
// Module : wb_trace_reg
// Registered record of the last committed write plus a committed-write count.
// Rev    : 1.0
// ============================================================================
module wb_trace_reg
   import wb_regfile_pkg::*;
#(
   parameter int DATA_W = c_reg_w,
   parameter int ADDR_W = c_reg_addr_w
) (
   input  wire logic              clk,
   input  wire logic              rst,
   input  wire logic              i_commit,
   input  wire logic [ADDR_W-1:0] i_waddr,
   input  wire logic [DATA_W-1:0] i_wdata,
   input  wire logic [31:0]       i_pc,
   output logic [31:0]            o_debug_wb_pc,
   output trace_wen_t             o_debug_wb_rf_wen,
   output logic [ADDR_W-1:0]      o_debug_wb_rf_wnum,
   output logic [DATA_W-1:0]      o_debug_wb_rf_wdata,
   output logic [31:0]            o_wr_count
);

   logic [31:0]       r_pc;
   trace_wen_t        r_wen;
   logic [ADDR_W-1:0] r_wnum;
   logic [DATA_W-1:0] r_wdata;
   logic [31:0]       r_wr_count;

   always_ff @(posedge clk) begin
      if (rst == c_rst_enable) begin
         r_pc       <= '0;
         r_wen      <= '0;
         r_wnum     <= '0;
         r_wdata    <= '0;
         r_wr_count <= '0;
      end else begin
         // The PC follows every retiring slot, even ones that do not commit.
         r_pc    <= i_pc;
         r_wen   <= f_trace_wen(i_commit);
         r_wnum  <= i_commit ? i_waddr : '0;
         r_wdata <= i_commit ? i_wdata : '0;
         if (i_commit) begin
            r_wr_count <= r_wr_count + 32'd1;
         end
      end
   end

   assign o_debug_wb_pc       = r_pc;
   assign o_debug_wb_rf_wen   = r_wen;
   assign o_debug_wb_rf_wnum  = r_wnum;
   assign o_debug_wb_rf_wdata = r_wdata;
   assign o_wr_count          = r_wr_count;

endmodule
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module : wb_regfile
// Register file with two bypassed combinational read ports and a write trace.
// Rev    : 1.0
// ============================================================================
module wb_regfile
   import wb_regfile_pkg::*;
#(
   parameter int DATA_W   = c_reg_w,
   parameter int ADDR_W   = c_reg_addr_w,
   parameter int NUM_REGS = c_reg_num
) (
   input  wire logic    clk,
   input  wire logic    rst,
   wb_regfile_if.slave  bus
);

   localparam logic [ADDR_W-1:0] c_zero_addr = ADDR_W'(c_nop_reg_addr);
   localparam logic [DATA_W-1:0] c_zero_data = DATA_W'(c_zero_word);

   logic [DATA_W-1:0] r_regs [NUM_REGS];
   logic              w_commit;

   assign w_commit = (bus.wb_write == c_write_enable) &&
                     (bus.wb_waddr != c_zero_addr) &&
                     (rst != c_rst_enable);

   // Entry 0 is never written, so it stays at its reset value of zero.
   always_ff @(posedge clk) begin
      if (rst == c_rst_enable) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= c_zero_data;
         end
      end else if (w_commit) begin
         r_regs[bus.wb_waddr] <= bus.wb_wdata;
      end
   end

   always_comb begin
      bus.rdata1 = c_zero_data;
      if (rst != c_rst_enable && bus.re1 == c_read_enable && bus.raddr1 != c_zero_addr) begin
         if (w_commit && bus.raddr1 == bus.wb_waddr) begin
            bus.rdata1 = bus.wb_wdata;
         end else begin
            bus.rdata1 = r_regs[bus.raddr1];
         end
      end
   end

   always_comb begin
      bus.rdata2 = c_zero_data;
      if (rst != c_rst_enable && bus.re2 == c_read_enable && bus.raddr2 != c_zero_addr) begin
         if (w_commit && bus.raddr2 == bus.wb_waddr) begin
            bus.rdata2 = bus.wb_wdata;
         end else begin
            bus.rdata2 = r_regs[bus.raddr2];
         end
      end
   end

   wb_trace_reg #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_trace (
      .clk                 (clk),
      .rst                 (rst),
      .i_commit            (w_commit),
      .i_waddr             (bus.wb_waddr),
      .i_wdata             (bus.wb_wdata),
      .i_pc                (bus.wb_pc),
      .o_debug_wb_pc       (bus.debug_wb_pc),
      .o_debug_wb_rf_wen   (bus.debug_wb_rf_wen),
      .o_debug_wb_rf_wnum  (bus.debug_wb_rf_wnum),
      .o_debug_wb_rf_wdata (bus.debug_wb_rf_wdata),
      .o_wr_count          (bus.wr_count)
   );

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
// Module : tb_wb_regfile
// Scoreboard bench for wb_regfile: read ports, bypass, trace record, counter.
// Rev    : 1.0
// ============================================================================
module tb_wb_regfile;

   typedef struct {
      logic [31:0] pc;
      logic [3:0]  wen;
      logic [4:0]  wnum;
      logic [31:0] wdata;
      logic [31:0] cnt;
   } trace_t;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   logic [31:0] m_regs [32];
   logic [31:0] m_count;
   trace_t      sb_q [$];

   wb_regfile_if #(.DATA_W(32), .ADDR_W(5)) bus ();

   wb_regfile #(
      .DATA_W   (32),
      .ADDR_W   (5),
      .NUM_REGS (32)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [31:0] exp_read(input logic r, input logic w, input logic [4:0] wa,
                                            input logic [31:0] wd, input logic re,
                                            input logic [4:0] ra);
      if (r || !re || ra == 5'd0) return 32'h0;
      if (w && wa != 5'd0 && ra == wa) return wd;
      return m_regs[ra];
   endfunction

   // One clock cycle: drive at negedge, check reads before the edge, check trace after it.
   task automatic step(input string tag, input logic r, input logic w, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [31:0] pc,
                       input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2);
      trace_t exp, got;
      logic [31:0] x1, x2;
      logic commit;
      @(negedge clk);
      rst = r;
      bus.wb_write = w; bus.wb_waddr = wa; bus.wb_wdata = wd; bus.wb_pc = pc;
      bus.re1 = e1; bus.raddr1 = a1; bus.re2 = e2; bus.raddr2 = a2;
      commit = !r && w && (wa != 5'd0);
      if (r) begin
         exp = '{pc: 32'h0, wen: 4'h0, wnum: 5'd0, wdata: 32'h0, cnt: 32'h0};
      end else begin
         exp.pc    = pc;
         exp.wen   = commit ? 4'hF : 4'h0;
         exp.wnum  = commit ? wa : 5'd0;
         exp.wdata = commit ? wd : 32'h0;
         exp.cnt   = commit ? m_count + 32'd1 : m_count;
      end
      sb_q.push_back(exp);
      x1 = exp_read(r, w, wa, wd, e1, a1);
      x2 = exp_read(r, w, wa, wd, e2, a2);
      #1;
      checks++;
      if (bus.rdata1 !== x1) begin
         failures++;
         $display("FAIL %s rdata1: got %h expected %h", tag, bus.rdata1, x1);
      end
      checks++;
      if (bus.rdata2 !== x2) begin
         failures++;
         $display("FAIL %s rdata2: got %h expected %h", tag, bus.rdata2, x2);
      end
      @(posedge clk);
      #1;
      if (r) begin
         for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
         m_count = 32'h0;
      end else if (commit) begin
         m_regs[wa] = wd;
         m_count = exp.cnt;
      end
      checks++;
      if (sb_q.size() == 0) begin
         failures++;
         $display("FAIL %s scoreboard: got empty expected entry", tag);
      end else begin
         got = sb_q.pop_front();
         checks++;
         if (bus.debug_wb_pc !== got.pc) begin
            failures++;
            $display("FAIL %s debug_wb_pc: got %h expected %h", tag, bus.debug_wb_pc, got.pc);
         end
         checks++;
         if (bus.debug_wb_rf_wen !== got.wen) begin
            failures++;
            $display("FAIL %s debug_wb_rf_wen: got %h expected %h", tag, bus.debug_wb_rf_wen, got.wen);
         end
         checks++;
         if (bus.debug_wb_rf_wnum !== got.wnum) begin
            failures++;
            $display("FAIL %s debug_wb_rf_wnum: got %h expected %h", tag, bus.debug_wb_rf_wnum, got.wnum);
         end
         checks++;
         if (bus.debug_wb_rf_wdata !== got.wdata) begin
            failures++;
            $display("FAIL %s debug_wb_rf_wdata: got %h expected %h", tag, bus.debug_wb_rf_wdata, got.wdata);
         end
         checks++;
         if (bus.wr_count !== got.cnt) begin
            failures++;
            $display("FAIL %s wr_count: got %h expected %h", tag, bus.wr_count, got.cnt);
         end
      end
   endtask

   task automatic test_reset();
      step("rst0", 1'b1, 1'b1, 5'd4, 32'h1111_2222, 32'h100, 1'b1, 5'd4, 1'b1, 5'd4);
      step("rst1", 1'b1, 1'b0, 5'd0, 32'h0, 32'h104, 1'b1, 5'd5, 1'b1, 5'd31);
      step("rst_read", 1'b0, 1'b0, 5'd0, 32'h0, 32'h108, 1'b1, 5'd5, 1'b1, 5'd31);
   endtask

   task automatic test_write_read();
      step("wr3", 1'b0, 1'b1, 5'd3, 32'hDEAD_BEEF, 32'h200, 1'b0, 5'd0, 1'b0, 5'd0);
      step("rd3", 1'b0, 1'b0, 5'd0, 32'h0, 32'h204, 1'b1, 5'd3, 1'b1, 5'd3);
      step("wr31", 1'b0, 1'b1, 5'd31, 32'h0BAD_F00D, 32'h208, 1'b1, 5'd3, 1'b0, 5'd31);
      step("rd31", 1'b0, 1'b0, 5'd31, 32'h0, 32'h20C, 1'b1, 5'd31, 1'b1, 5'd3);
   endtask

   task automatic test_bypass();
      step("byp7", 1'b0, 1'b1, 5'd7, 32'h1234_5678, 32'h300, 1'b1, 5'd7, 1'b1, 5'd7);
      step("byp_p2", 1'b0, 1'b1, 5'd3, 32'hCAFE_0003, 32'h304, 1'b1, 5'd7, 1'b1, 5'd3);
      step("byp_off", 1'b0, 1'b1, 5'd8, 32'h8888_8888, 32'h308, 1'b0, 5'd8, 1'b1, 5'd8);
      step("after_byp", 1'b0, 1'b0, 5'd7, 32'hFFFF_0000, 32'h30C, 1'b1, 5'd7, 1'b1, 5'd3);
   endtask

   task automatic test_zero_write();
      step("wr0", 1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 32'h400, 1'b1, 5'd0, 1'b1, 5'd0);
      step("rd0", 1'b0, 1'b0, 5'd0, 32'h0, 32'h404, 1'b1, 5'd0, 1'b1, 5'd7);
   endtask

   task automatic test_reset_collision();
      step("col_rst", 1'b1, 1'b1, 5'd9, 32'hA5A5_A5A5, 32'h500, 1'b1, 5'd9, 1'b1, 5'd9);
      step("col_rd", 1'b0, 1'b0, 5'd0, 32'h0, 32'h504, 1'b1, 5'd9, 1'b1, 5'd3);
      step("wr9", 1'b0, 1'b1, 5'd9, 32'h5555_AAAA, 32'h508, 1'b0, 5'd0, 1'b0, 5'd0);
      step("re_off", 1'b0, 1'b0, 5'd0, 32'h0, 32'h50C, 1'b0, 5'd9, 1'b1, 5'd9);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 60; i++) begin
         step("b2b", 1'b0, 1'($urandom_range(0, 3) != 0), 5'($urandom), $urandom, $urandom,
              1'($urandom_range(0, 7) != 0), 5'($urandom), 1'($urandom_range(0, 7) != 0), 5'($urandom));
      end
   endtask

   task automatic test_counter_wrap();
      step("wrap_idle", 1'b0, 1'b0, 5'd0, 32'h0, 32'h600, 1'b0, 5'd0, 1'b0, 5'd0);
      force dut.u_trace.r_wr_count = 32'hFFFF_FFFE;
      #1;
      release dut.u_trace.r_wr_count;
      m_count = 32'hFFFF_FFFE;
      step("wrap1", 1'b0, 1'b1, 5'd10, 32'h0000_000A, 32'h604, 1'b1, 5'd10, 1'b0, 5'd0);
      step("wrap2", 1'b0, 1'b1, 5'd11, 32'h0000_000B, 32'h608, 1'b1, 5'd10, 1'b1, 5'd11);
      step("wrap3", 1'b0, 1'b1, 5'd12, 32'h0000_000C, 32'h60C, 1'b1, 5'd11, 1'b1, 5'd12);
      step("wrap_hold", 1'b0, 1'b1, 5'd0, 32'h0000_000D, 32'h610, 1'b1, 5'd12, 1'b1, 5'd10);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      m_count  = 32'h0;
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      rst = 1'b1;
      bus.wb_write = 1'b0; bus.wb_waddr = '0; bus.wb_wdata = '0; bus.wb_pc = '0;
      bus.re1 = 1'b0; bus.raddr1 = '0; bus.re2 = 1'b0; bus.raddr2 = '0;

      test_reset();
      test_write_read();
      test_bypass();
      test_zero_write();
      test_reset_collision();
      test_back_to_back();
      test_counter_wrap();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
